acc_bank: RTL

Multi-channel block accumulator for the 18-bit signed datapath. It replaces the single-register accumulate stage.
- Sums BLOCK_LEN signed samples per channel on a time-multiplexed input stream.
- Emits one widened sum per completed block through a single-entry valid/ready output register.
- Sits between the filter/MAC stage and downstream result consumers.

---
 rtl/acc_bank.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/acc_bank.sv
// Multi-channel signed block accumulator with a single-entry valid/ready result register.
// Optional build macro ACC_BANK_SAT_EN: saturating adds and a sticky sat_flag.
module acc_bank #(
    parameter int unsigned DATA_W    = 18,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned BLOCK_LEN = 8,
    parameter int unsigned CH_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [ACC_W-1:0]  out_data,
    output logic              sat_flag
);

    localparam int unsigned CntW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(BLOCK_LEN - 1);

    typedef enum logic [0:0] {StEmpty, StFull} out_state_e;

    out_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q [CHANNELS];
    logic [ACC_W-1:0]  acc_d [CHANNELS];
    logic [CntW-1:0]   cnt_q [CHANNELS];
    logic [CntW-1:0]   cnt_d [CHANNELS];
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;

    logic              ch_ok;
    logic              accept;
    logic              blk_done;
    logic [ACC_W-1:0]  acc_sel;
    logic [CntW-1:0]   cnt_sel;
    logic [ACC_W-1:0]  ext_data;
    logic [ACC_W-1:0]  sum;

    // Channel select; out-of-range indices match nothing and are dropped.
    always_comb begin
        acc_sel = '0;
        cnt_sel = '0;
        ch_ok   = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (in_ch == CH_W'(i)) begin
                acc_sel = acc_q[i];
                cnt_sel = cnt_q[i];
                ch_ok   = 1'b1;
            end
        end
    end

    assign ext_data = ACC_W'($signed(in_data));

`ifdef ACC_BANK_SAT_EN
    logic [ACC_W:0] sum_wide;
    logic           ovf;
    logic           sat_q, sat_d;

    always_comb begin
        sum_wide = {acc_sel[ACC_W-1], acc_sel} + {ext_data[ACC_W-1], ext_data};
        ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        if (!ovf) begin
            sum = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            sum = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sum = {1'b0, {(ACC_W-1){1'b1}}};
        end
        sat_d = clear ? 1'b0 : (sat_q | (accept & ovf));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    assign sum      = acc_sel + ext_data;
    assign sat_flag = 1'b0;
`endif

    assign out_valid = (state_q == StFull);
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign in_ready  = !clear && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready && ch_ok;
    assign blk_done  = accept && (cnt_sel == LastCnt);

    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            acc_d[i] = acc_q[i];
            cnt_d[i] = cnt_q[i];
            if (clear) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end else if (accept && (in_ch == CH_W'(i))) begin
                if (blk_done) begin
                    acc_d[i] = '0;
                    cnt_d[i] = '0;
                end else begin
                    acc_d[i] = sum;
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // A completing accept while full can only happen with out_ready high, so it replaces in place.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        case (state_q)
            StEmpty: if (blk_done) state_d = StFull;
            StFull: begin
                if (blk_done) begin
                    state_d = StFull;
                end else if (out_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (blk_done) begin
            out_data_d = sum;
            out_ch_d   = in_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StEmpty;
            out_data_q <= '0;
            out_ch_q   <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= acc_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
